qam_mapper: RTL and testbench

QAM_MAPPER -- requirements
Module: qam_mapper

---
 rtl/qam_mapper.sv | 175 +++++++++++++++++
 tb/tb_qam_mapper.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_mapper.sv
// ----------------------------------------------------------------------------
// qam_mapper
//
// Collects a serial bit stream into QPSK (2-bit) or 16-QAM (4-bit, Gray
// coded) symbols and presents each symbol as an offset-binary I/Q pair behind
// a valid/ready handshake. The mode is captured on the first bit of a symbol,
// so toggling it mid-symbol only affects the following symbol.
//
// Parameters:
//   OUT_W  width of each I/Q output word (offset binary, MID = 2^(OUT_W-1))
//   AMP    unit amplitude step; levels are MID +/- AMP and MID +/- 3*AMP
//   CNT_W  width of the consumed-symbol counter
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   mode       in   0 = QPSK, 1 = 16-QAM (sampled on the first bit of a symbol)
//   flush      in   discard the partially collected symbol (wins over a bit)
//   bit_in     in   serial data bit
//   bit_valid  in   qualifies bit_in
//   bit_ready  out  bit_in is accepted this cycle when bit_valid is also high
//   i_out      out  in-phase level
//   q_out      out  quadrature level
//   sym_mode   out  mode the presented symbol was built with
//   sym_valid  out  i_out/q_out/sym_mode hold a symbol
//   sym_ready  in   downstream consumes the presented symbol
//   sym_count  out  number of symbols consumed (wraps)
// ----------------------------------------------------------------------------
module qam_mapper #(
    parameter int OUT_W = 8,
    parameter int AMP   = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             mode,
    input  logic             flush,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [OUT_W-1:0] i_out,
    output logic [OUT_W-1:0] q_out,
    output logic             sym_mode,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic [CNT_W-1:0] sym_count
);

    // The outermost level must stay inside the offset-binary range.
    generate
        if (3 * AMP >= 2 ** (OUT_W - 1)) begin : g_amp_check
            $error("qam_mapper: 3*AMP must be less than 2^(OUT_W-1)");
        end
    endgenerate

    // Levels are formed at OUT_W+1 signed bits; the range check above
    // guarantees the low OUT_W bits never wrap.
    localparam int                MID    = 2 ** (OUT_W - 1);
    localparam logic signed [OUT_W:0] MID_S  = (OUT_W + 1)'(MID);
    localparam logic signed [OUT_W:0] AMP_S  = (OUT_W + 1)'(AMP);
    localparam logic signed [OUT_W:0] LVL_M3 = MID_S - AMP_S - AMP_S - AMP_S;
    localparam logic signed [OUT_W:0] LVL_M1 = MID_S - AMP_S;
    localparam logic signed [OUT_W:0] LVL_P1 = MID_S + AMP_S;
    localparam logic signed [OUT_W:0] LVL_P3 = MID_S + AMP_S + AMP_S + AMP_S;
    localparam logic [OUT_W-1:0]      LVL_MID = MID_S[OUT_W-1:0];

    // QPSK: bit 0 -> +AMP, bit 1 -> -AMP
    function automatic logic [OUT_W-1:0] qpsk_level(input logic b);
        return b ? LVL_M1[OUT_W-1:0] : LVL_P1[OUT_W-1:0];
    endfunction

    // 16-QAM Gray pair (first bit, second bit): 00 -3, 01 -1, 11 +1, 10 +3
    function automatic logic [OUT_W-1:0] gray_level(input logic [1:0] bb);
        logic [OUT_W-1:0] lvl;
        case (bb)
            2'b00:   lvl = LVL_M3[OUT_W-1:0];
            2'b01:   lvl = LVL_M1[OUT_W-1:0];
            2'b11:   lvl = LVL_P1[OUT_W-1:0];
            default: lvl = LVL_P3[OUT_W-1:0];
        endcase
        return lvl;
    endfunction

    // Collector state
    logic [1:0]       r_cnt;
    logic [3:0]       r_shift;     // oldest bit at the highest used position
    logic             r_mode_q;

    // Output register
    logic [OUT_W-1:0] r_i_out;
    logic [OUT_W-1:0] r_q_out;
    logic             r_sym_mode;
    logic             r_sym_valid;
    logic [CNT_W-1:0] r_sym_count;

    logic             w_mode_eff;
    logic             w_last;
    logic             w_bit_acc;
    logic             w_load;
    logic             w_consume;
    logic [OUT_W-1:0] w_i_next;
    logic [OUT_W-1:0] w_q_next;

    // On the first bit the symbol length follows the incoming mode, since
    // mode_q has not been captured yet.
    assign w_mode_eff = (r_cnt == 2'd0) ? mode : r_mode_q;
    assign w_last     = w_mode_eff ? (r_cnt == 2'd3) : (r_cnt == 2'd1);
    assign w_consume  = r_sym_valid && sym_ready;

    // Only the completing bit can be stalled, and only by a full output
    // register that is not draining this cycle.
    assign bit_ready  = !(w_last && r_sym_valid && !sym_ready);
    assign w_bit_acc  = bit_valid && bit_ready;
    assign w_load     = w_bit_acc && w_last && !flush;

    // The completing bit is never the first one, so mode_q is already valid.
    // QPSK: b0 = shift[0], b1 = bit_in.
    // 16-QAM: b0 = shift[2], b1 = shift[1], b2 = shift[0], b3 = bit_in.
    always_comb begin
        w_i_next = LVL_MID;
        w_q_next = LVL_MID;
        if (r_mode_q) begin
            w_i_next = gray_level({r_shift[2], r_shift[1]});
            w_q_next = gray_level({r_shift[0], bit_in});
        end else begin
            w_i_next = qpsk_level(r_shift[0]);
            w_q_next = qpsk_level(bit_in);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_cnt       <= 2'd0;
            r_shift     <= 4'd0;
            r_mode_q    <= 1'b0;
            r_i_out     <= LVL_MID;
            r_q_out     <= LVL_MID;
            r_sym_mode  <= 1'b0;
            r_sym_valid <= 1'b0;
            r_sym_count <= '0;
        end else begin
            if (flush) begin
                r_cnt <= 2'd0;
            end else if (w_bit_acc) begin
                r_shift <= {r_shift[2:0], bit_in};
                if (r_cnt == 2'd0) begin
                    r_mode_q <= mode;
                end
                r_cnt <= w_last ? 2'd0 : r_cnt + 2'd1;
            end

            if (w_load) begin
                r_i_out     <= w_i_next;
                r_q_out     <= w_q_next;
                r_sym_mode  <= r_mode_q;
                r_sym_valid <= 1'b1;
            end else if (w_consume) begin
                r_sym_valid <= 1'b0;
            end

            if (w_consume) begin
                r_sym_count <= r_sym_count + CNT_W'(1);
            end
        end
    end

    assign i_out     = r_i_out;
    assign q_out     = r_q_out;
    assign sym_mode  = r_sym_mode;
    assign sym_valid = r_sym_valid;
    assign sym_count = r_sym_count;

endmodule

// File: tb/tb_qam_mapper.sv
// ----------------------------------------------------------------------------
// tb_qam_mapper
//
// Scoreboard bench for qam_mapper. The driver hands bits to the DUT and feeds
// the same bits to a symbol-level reference model; completed symbols are
// pushed into an expected queue. A separate monitor pops and compares every
// time the DUT hands a symbol downstream.
// ----------------------------------------------------------------------------
module tb_qam_mapper;

    localparam int OUT_W = 8;
    localparam int AMP   = 32;
    localparam int CNT_W = 4;
    localparam int MID   = 2 ** (OUT_W - 1);

    logic             CLOCK_50 = 1'b0;
    logic             reset    = 1'b1;
    logic             mode     = 1'b0;
    logic             flush    = 1'b0;
    logic             bit_in   = 1'b0;
    logic             bit_valid = 1'b0;
    logic             bit_ready;
    logic [OUT_W-1:0] i_out;
    logic [OUT_W-1:0] q_out;
    logic             sym_mode;
    logic             sym_valid;
    logic             sym_ready = 1'b1;
    logic [CNT_W-1:0] sym_count;

    qam_mapper #(.OUT_W(OUT_W), .AMP(AMP), .CNT_W(CNT_W)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .mode      (mode),
        .flush     (flush),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .i_out     (i_out),
        .q_out     (q_out),
        .sym_mode  (sym_mode),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_count (sym_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: bits of the symbol being built, its mode, and the
    // queue of symbols expected downstream in order.
    // ------------------------------------------------------------------
    typedef struct {
        int i;
        int q;
        int m;
    } sym_t;

    sym_t exp_q[$];
    int   partial[$];
    int   model_mode = 0;
    int   exp_count  = 0;

    function automatic int lvl_qpsk(input int b);
        return (b != 0) ? MID - AMP : MID + AMP;
    endfunction

    function automatic int lvl_gray(input int first, input int second);
        int steps[4] = '{-3, -1, 3, 1};   // index = first*2 + second
        return MID + steps[first * 2 + second] * AMP;
    endfunction

    function automatic int sym_len(input int m_in);
        int m;
        m = (partial.size() == 0) ? m_in : model_mode;
        return (m != 0) ? 4 : 2;
    endfunction

    function automatic bit model_is_last(input int m_in);
        return partial.size() == sym_len(m_in) - 1;
    endfunction

    task automatic model_accept(input int b, input int m);
        sym_t s;
        if (partial.size() == 0) model_mode = m;
        partial.push_back(b);
        if (partial.size() == ((model_mode != 0) ? 4 : 2)) begin
            if (model_mode != 0) begin
                s.i = lvl_gray(partial[0], partial[1]);
                s.q = lvl_gray(partial[2], partial[3]);
            end else begin
                s.i = lvl_qpsk(partial[0]);
                s.q = lvl_qpsk(partial[1]);
            end
            s.m = model_mode;
            exp_q.push_back(s);
            partial.delete();
        end
    endtask

    // ------------------------------------------------------------------
    // Downstream ready generator: 0 = always ready, 1 = random, 2 = stalled
    // ------------------------------------------------------------------
    int rdy_mode = 0;

    initial begin
        forever begin
            @(posedge CLOCK_50);
            #1;
            case (rdy_mode)
                0:       sym_ready = 1'b1;
                2:       sym_ready = 1'b0;
                default: sym_ready = ($urandom % 4) != 0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares on each negedge, ahead of the edge that consumes
    // ------------------------------------------------------------------
    initial begin
        sym_t e;
        bit               hold = 0;
        logic [OUT_W-1:0] h_i, h_q;
        logic             h_m;
        forever begin
            @(negedge CLOCK_50);
            if (reset) begin
                hold = 0;
            end else begin
                check("sym_valid", sym_valid, exp_q.size() != 0);
                check("sym_count", sym_count, exp_count);
                if (hold && sym_valid) begin
                    check("hold_i", i_out, h_i);
                    check("hold_q", q_out, h_q);
                    check("hold_mode", sym_mode, h_m);
                end
                hold = sym_valid && !sym_ready;
                h_i  = i_out;
                h_q  = q_out;
                h_m  = sym_mode;
                if (sym_valid && sym_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_symbol", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sym_i", i_out, e.i);
                        check("sym_q", q_out, e.q);
                        check("sym_mode", sym_mode, e.m);
                    end
                    exp_count = (exp_count + 1) % (2 ** CNT_W);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks: all start and end at posedge + 1
    // ------------------------------------------------------------------
    task automatic send_bit(input int b, input int m);
        int waited = 0;
        bit done   = 0;
        bit_valid = 1'b1;
        bit_in    = b[0];
        mode      = m[0];
        while (!done) begin
            @(negedge CLOCK_50);
            check("bit_ready", bit_ready,
                  !(model_is_last(m) && exp_q.size() != 0 && !sym_ready));
            if (bit_ready) begin
                done = 1;
            end else if (++waited > 500) begin
                check("bit_accept_timeout", 0, 1);
                break;
            end
            @(posedge CLOCK_50);
            if (done) model_accept(b, m);
            #1;
        end
        if (!done) #1;
        bit_valid = 1'b0;
    endtask

    task automatic flush_with_bit(input int b, input int m);
        flush     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = b[0];
        mode      = m[0];
        @(posedge CLOCK_50);
        partial.delete();
        #1;
        flush     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drain();
        int waited = 0;
        rdy_mode  = 0;
        sym_ready = 1'b1;
        while ((exp_q.size() != 0 || sym_valid) && waited < 20) begin
            idle(1);
            waited++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        exp_q.delete();
        partial.delete();
        exp_count = 0;
        idle(2);
        reset = 1'b0;
        idle(1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset state
        repeat (2) @(posedge CLOCK_50);
        #1;
        check("rst_sym_valid", sym_valid, 0);
        check("rst_i_out", i_out, MID);
        check("rst_q_out", q_out, MID);
        check("rst_sym_mode", sym_mode, 0);
        check("rst_sym_count", sym_count, 0);
        reset = 1'b0;
        idle(1);
        check("rst_bit_ready", bit_ready, 1);

        // QPSK 0,1 -> I=160, Q=96, visible one cycle after the last bit
        rdy_mode = 0;
        send_bit(0, 0);
        send_bit(1, 0);
        check("qpsk01_valid", sym_valid, 1);
        check("qpsk01_i", i_out, 160);
        check("qpsk01_q", q_out, 96);
        check("qpsk01_mode", sym_mode, 0);

        // 16-QAM 1,0,0,1 -> I=224, Q=96
        send_bit(1, 1);
        send_bit(0, 1);
        send_bit(0, 1);
        send_bit(1, 1);
        check("qam1001_i", i_out, 224);
        check("qam1001_q", q_out, 96);
        check("qam1001_mode", sym_mode, 1);

        // Every 16-QAM symbol, with random downstream backpressure
        rdy_mode = 1;
        for (int v = 0; v < 16; v++) begin
            send_bit((v >> 3) & 1, 1);
            send_bit((v >> 2) & 1, 1);
            send_bit((v >> 1) & 1, 1);
            send_bit(v & 1, 1);
        end
        drain();

        // Stalled output: first symbol held, completing bit waits, then the
        // held bit is taken on the same edge the old symbol is consumed
        rdy_mode  = 2;
        sym_ready = 1'b0;
        send_bit(0, 0);
        send_bit(1, 0);
        send_bit(1, 0);
        fork
            send_bit(0, 0);
            begin
                repeat (3) @(negedge CLOCK_50);
                check("stall_bit_ready", bit_ready, 0);
                check("stall_valid", sym_valid, 1);
                @(posedge CLOCK_50);
                #1;
                rdy_mode  = 0;
                sym_ready = 1'b1;
            end
        join
        check("stall_next_valid", sym_valid, 1);
        check("stall_next_i", i_out, 96);
        check("stall_next_q", q_out, 160);
        drain();

        // Mode toggled after the first bit: this symbol QPSK, next 16-QAM
        rdy_mode = 1;
        send_bit(1, 0);
        send_bit(1, 1);
        send_bit(0, 1);
        send_bit(1, 1);
        send_bit(1, 1);
        send_bit(0, 1);
        drain();

        // Flush on the third 16-QAM bit drops it; next four bits form a symbol
        send_bit(1, 1);
        send_bit(1, 1);
        flush_with_bit(0, 1);
        send_bit(0, 1);
        send_bit(0, 1);
        send_bit(1, 1);
        send_bit(1, 1);
        check("flush_next_i", i_out, 32);
        check("flush_next_q", q_out, 160);
        check("flush_next_mode", sym_mode, 1);
        drain();

        // Reset with a pending output and a partial symbol
        rdy_mode  = 2;
        sym_ready = 1'b0;
        send_bit(0, 0);
        send_bit(0, 0);
        send_bit(1, 1);
        reset = 1'b1;
        #2;
        check("midrst_valid", sym_valid, 0);
        check("midrst_i", i_out, MID);
        check("midrst_q", q_out, MID);
        check("midrst_mode", sym_mode, 0);
        check("midrst_count", sym_count, 0);
        exp_q.delete();
        partial.delete();
        exp_count = 0;
        idle(2);
        reset    = 1'b0;
        rdy_mode = 0;
        idle(1);
        check("postrst_bit_ready", bit_ready, 1);
        send_bit(1, 0);
        send_bit(0, 0);
        check("postrst_i", i_out, 96);
        check("postrst_q", q_out, 160);
        check("postrst_mode", sym_mode, 0);
        drain();

        // Random traffic: bits, modes, gaps, flushes and backpressure
        rdy_mode = 1;
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom % 20;
            if (r == 0) flush_with_bit($urandom % 2, $urandom % 2);
            else if (r < 4) idle(1 + $urandom % 3);
            else send_bit($urandom % 2, $urandom % 2);
        end
        drain();

        // 17 consumed symbols with a 4-bit counter wrap to 1
        do_reset();
        rdy_mode = 0;
        for (int s = 0; s < 17; s++) begin
            send_bit(s & 1, 0);
            send_bit((s >> 1) & 1, 0);
        end
        drain();
        check("count_wrap", sym_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global bound on simulated time
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
